// File: rtl/timer.sv
// Retriggerable period timer.
// A start seen while idle launches a period of STOP_COUNT cycles; done is a
// one-cycle pulse on the last cycle of the period. A start seen during the
// done cycle chains straight into the next period with no idle gap.
`timescale 1ns/1ps
module timer #(
  parameter int STOP_COUNT = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  // Counter is wide enough to hold STOP_COUNT itself without wrapping.
  localparam int CNT_W = (STOP_COUNT < 1) ? 1 : $clog2(STOP_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(STOP_COUNT);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic             at_stop;

  // Last cycle of the current period, decoded from registered state only.
  assign at_stop = (state_q == RUN) && (cnt_q == CNT_STOP);

  // Next-state, next-count and next-done decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end
      end
      RUN: begin
        if (!at_stop) begin
          // start is deliberately ignored mid-period: no restart, no extension.
          cnt_d = cnt_q + CNT_ONE;
        end else if (start) begin
          // Seamless retrigger: the done cycle counts as cycle 0 of the next
          // period, so the next period resumes at 1.
          cnt_d = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    // done is registered from the next-state values, so it equals
    // (RUN && cnt==STOP_COUNT) of the flops and cannot glitch on start.
    done_d = (state_d == RUN) && (cnt_d == CNT_STOP);
  end

  // State, counter and done registers; reset forces idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: three instances (101, 900, 1 cycles) sharing
// clk, rst_n and start. A monitor logs the cycle number of every cycle in
// which each done output is high; steps compare those logs against
// hand-computed cycle numbers relative to the accepting edge.
`timescale 1ns/1ps
module tb_timer;

  logic clk;
  logic rst_n;
  logic start;
  logic done0, done1, done2;

  int cyc;
  int total;
  int bad;
  int q0[$];
  int q1[$];
  int q2[$];

  timer #(.STOP_COUNT(101)) u_t101 (.clk(clk), .rst_n(rst_n), .start(start), .done(done0));
  timer #(.STOP_COUNT(900)) u_t900 (.clk(clk), .rst_n(rst_n), .start(start), .done(done1));
  timer #(.STOP_COUNT(1))   u_t1   (.clk(clk), .rst_n(rst_n), .start(start), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == N after the Nth rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // log cycles in which done is high, sampled mid-cycle
  always @(negedge clk) begin
    if (done0 === 1'b1) q0.push_back(cyc);
    if (done1 === 1'b1) q1.push_back(cyc);
    if (done2 === 1'b1) q2.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start(output int e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    e = cyc;
    start = 1'b0;
  endtask

  task automatic begin_hold(output int e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    e = cyc;
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  int e0, e1, e2;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b1;  // must be ignored while in reset

    // reset state
    repeat (4) @(negedge clk);
    chk("reset_done0", int'(done0), 0);
    chk("reset_done1", int'(done1), 0);
    chk("reset_done2", int'(done2), 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_no_pulse0", q0.size(), 0);
    chk("reset_no_pulse2", q2.size(), 0);
    clear_logs();

    // single pulse, twice
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      pulse_start(e0);
      wait_until(e0 + 920);
      chk("single_cnt0",  q0.size(), 1);
      chk("single_at0",   at(q0, 0), e0 + 101);
      chk("single_cnt1",  q1.size(), 1);
      chk("single_at1",   at(q1, 0), e0 + 900);
      chk("single_cnt2",  q2.size(), 1);
      chk("single_at2",   at(q2, 0), e0 + 1);
    end

    // held start, then repeated 20 cycles after going idle
    clear_logs();
    begin_hold(e0);
    wait_until(e0 + 202);
    start = 1'b0;
    @(negedge clk);
    chk("held_idle_done0", int'(done0), 0);
    chk("held_idle_done2", int'(done2), 0);
    wait_until(e0 + 223);
    chk("held_cnt0_a", q0.size(), 2);
    chk("held_at0_a",  at(q0, 0), e0 + 101);
    chk("held_at0_b",  at(q0, 1), e0 + 202);
    chk("held_cnt2_a", q2.size(), 202);
    chk("held_last2_a", at(q2, 201), e0 + 202);
    begin_hold(e1);
    wait_until(e1 + 202);
    start = 1'b0;
    wait_until(e0 + 930);
    chk("held_cnt0_b", q0.size(), 4);
    chk("held_at0_c",  at(q0, 2), e1 + 101);
    chk("held_at0_d",  at(q0, 3), e1 + 202);
    chk("held_cnt1",   q1.size(), 1);
    chk("held_at1",    at(q1, 0), e0 + 900);
    chk("held_cnt2_b", q2.size(), 404);
    chk("held_first2_b", at(q2, 202), e1 + 1);
    chk("held_last2_b",  at(q2, 403), e1 + 202);

    // reset mid-period aborts without done, then a fresh start times normally
    clear_logs();
    pulse_start(e0);
    wait_until(e0 + 50);
    rst_n = 1'b0;
    #1;
    chk("midrst_done0", int'(done0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(e0 + 950);
    chk("midrst_cnt0", q0.size(), 0);
    chk("midrst_cnt1", q1.size(), 0);
    chk("midrst_cnt2", q2.size(), 1);
    clear_logs();
    pulse_start(e2);
    wait_until(e2 + 920);
    chk("afterrst_cnt0", q0.size(), 1);
    chk("afterrst_at0",  at(q0, 0), e2 + 101);
    chk("afterrst_at1",  at(q1, 0), e2 + 900);

    // asynchronous reset clears an active done without a clock edge
    clear_logs();
    begin_hold(e0);
    repeat (4) @(negedge clk);
    chk("async_pre_done2", int'(done2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_done2", int'(done2), 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // start re-pulsed mid-period is ignored
    clear_logs();
    pulse_start(e0);
    wait_until(e0 + 29);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(e0 + 920);
    chk("midstart_cnt0", q0.size(), 1);
    chk("midstart_at0",  at(q0, 0), e0 + 101);
    chk("midstart_cnt1", q1.size(), 1);
    chk("midstart_at1",  at(q1, 0), e0 + 900);
    chk("midstart_cnt2", q2.size(), 2);
    chk("midstart_at2",  at(q2, 1), e0 + 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL provide parameter STOP_COUNT, default 100, meaning the number of clock cycles from the start-accepting edge to the done edge; legal range is 1 to 2^20-1.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1 bit, a level-sampled request to begin or continue a timing period.
REQ-005 SHALL provide port done, output, 1 bit, the period-complete pulse.

Function
REQ-006 SHALL implement two states: IDLE, and RUN with an internal counter cnt.
REQ-007 SHALL size cnt as $clog2(STOP_COUNT+1) bits, so STOP_COUNT is representable without wrap.
REQ-008 On a rising edge in IDLE with start=1 (the accepting edge, E0): enter RUN with cnt=0.
REQ-009 On a rising edge in IDLE with start=0: remain IDLE.
REQ-010 On a rising edge in RUN with cnt<STOP_COUNT: cnt increments by 1; start is ignored (no restart, no extension).
REQ-011 On a rising edge in RUN with cnt==STOP_COUNT and start=1: cnt=1, staying in RUN (seamless retrigger).
REQ-012 On a rising edge in RUN with cnt==STOP_COUNT and start=0: return to IDLE.
REQ-013 done SHALL be 1 exactly while in RUN with cnt==STOP_COUNT, and 0 otherwise.
REQ-014 done SHALL be decoded from flops only (no combinational path from start), so it is glitch-free.
REQ-015 done SHALL rise on rising edge E0+STOP_COUNT and SHALL last exactly one clock cycle.
REQ-016 With start held high continuously, done SHALL pulse at E0+k*STOP_COUNT for k=1,2,…, each pulse one cycle wide.
REQ-017 A start pulse of any length that ends before the done cycle SHALL produce exactly one done pulse.
REQ-018 A start that is high during the done cycle SHALL retrigger per REQ-011, not add an extra idle cycle.
REQ-019 With STOP_COUNT=1: done SHALL rise at E0+1; with start held high, done SHALL stay 1 continuously.
REQ-020 Independent instances sharing clk, rst_n and start SHALL operate without interaction.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for a clock, force IDLE, cnt=0 and done=0.
REQ-022 Asserting rst_n mid-period SHALL abort the period with no done pulse.
REQ-023 While rst_n=0, start SHALL be ignored.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL be the accepting edge.

Verification
REQ-025 Single pulse: instances with STOP_COUNT=101 and 900 share start; start=1 for one cycle at E0 -> done[0] rises at E0+101 and done[1] rises at E0+900, each one cycle wide.
REQ-026 Repeat single pulse: repeat REQ-025 20 idle cycles after the 900 pulse -> same 101 and 900 latencies, no spurious pulses.
REQ-027 Held start: STOP_COUNT=101, start held high from E0 -> done pulses at E0+101 and E0+202; start dropped after the second pulse -> timer idle at E0+203, no third pulse.
REQ-028 Held start, repeated: repeat REQ-027 20 cycles later -> identical 101/202 timing, confirming a clean return to IDLE.
REQ-029 Reset mid-operation: rst_n pulsed low at E0+50 (STOP_COUNT=101) -> done stays 0, and a new start gives done exactly 101 cycles after its accepting edge.
REQ-030 Start while running: start re-pulsed at E0+30 (STOP_COUNT=101) -> done still at E0+101 and only once.
